// File: rtl/operations.sv
// rtl/operations.sv - S = ~A & B & C with registered copy, saturating rise counter, input coverage
// Define OPERATIONS_COV_EN to build the seen/all_seen coverage register; otherwise they are tied low.
module operations #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic             S,
  output logic             S_q,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [7:0]       seen,
  output logic             all_seen
);

  logic             s_reg_q, s_reg_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;

  assign S = ~A & B & C;

  always_comb begin
    s_reg_d    = S;
    rise_cnt_d = rise_cnt_q;
    // clr wins over a rising edge seen on the same clock
    if (clr) begin
      rise_cnt_d = '0;
    end else if (S && !s_reg_q && (rise_cnt_q != {CNT_W{1'b1}})) begin
      rise_cnt_d = rise_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg_q    <= 1'b0;
      rise_cnt_q <= '0;
    end else begin
      s_reg_q    <= s_reg_d;
      rise_cnt_q <= rise_cnt_d;
    end
  end

  assign S_q      = s_reg_q;
  assign rise_cnt = rise_cnt_q;

`ifdef OPERATIONS_COV_EN
  logic [7:0] seen_q, seen_d;

  always_comb begin
    seen_d = seen_q;
    if (clr) begin
      seen_d = 8'h00;
    end else begin
      seen_d[{A, B, C}] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= 8'h00;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign seen     = seen_q;
  assign all_seen = &seen_q;
`else
  assign seen     = 8'h00;
  assign all_seen = 1'b0;
`endif

endmodule

// File: tb/tb_operations.sv
// tb/tb_operations.sv - directed-vector bench for operations (CNT_W=8 and CNT_W=2 instances)
module tb_operations;

  logic       clk = 1'b0;
  logic       rst, clr, A, B, C;
  logic       S, S_q, S2, S_q2;
  logic [7:0] rise_cnt, seen, seen2;
  logic [1:0] rise_cnt2;
  logic       all_seen, all_seen2;

  int n_vec = 0;
  int n_bad = 0;

`ifdef OPERATIONS_COV_EN
  localparam logic [7:0] SEEN_FULL = 8'hFF;
  localparam logic       ALL_FULL  = 1'b1;
`else
  localparam logic [7:0] SEEN_FULL = 8'h00;
  localparam logic       ALL_FULL  = 1'b0;
`endif

  operations #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .A(A), .B(B), .C(C),
    .S(S), .S_q(S_q), .rise_cnt(rise_cnt), .seen(seen), .all_seen(all_seen)
  );

  operations #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .A(A), .B(B), .C(C),
    .S(S2), .S_q(S_q2), .rise_cnt(rise_cnt2), .seen(seen2), .all_seen(all_seen2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_abc(input logic [2:0] v);
    {A, B, C} = v;
  endtask

  // one high pulse of S: a cycle at 111 then a cycle at 011
  task automatic pulse;
    set_abc(3'b111); tick;
    set_abc(3'b011); tick;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    set_abc(3'b011);
    #2;
    check("rst_S", S, 1'b1);
    check("rst_S_q", S_q, 1'b0);
    check("rst_cnt", rise_cnt, 8'd0);
    check("rst_seen", seen, 8'h00);
    check("rst_all", all_seen, 1'b0);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_abc(i[2:0]);
      #1;
      check($sformatf("sweep_S_%0d", i), S, (i == 3) ? 1'b1 : 1'b0);
      tick;
      check($sformatf("sweep_S_q_%0d", i), S_q, (i == 3) ? 1'b1 : 1'b0);
    end
    check("sweep_cnt", rise_cnt, 8'd1);
    check("sweep_cnt2", rise_cnt2, 2'd1);
    check("sweep_seen", seen, SEEN_FULL);
    check("sweep_all", all_seen, ALL_FULL);

    set_abc(3'b011); clr = 1'b1;
    tick;
    clr = 1'b0;
    check("clr_cnt", rise_cnt, 8'd0);
    check("clr_seen", seen, 8'h00);
    check("clr_all", all_seen, 1'b0);
    check("clr_S_q", S_q, 1'b1);

    for (int k = 0; k < 5; k++) pulse();
    check("five_cnt", rise_cnt, 8'd5);
    check("five_cnt2_sat", rise_cnt2, 2'd3);
    pulse();
    check("six_cnt", rise_cnt, 8'd6);
    check("six_cnt2_sat", rise_cnt2, 2'd3);

    clr = 1'b1; tick; clr = 1'b0;
    for (int k = 0; k < 4; k++) pulse();
    check("four_cnt", rise_cnt, 8'd4);
    set_abc(3'b111); tick;
    set_abc(3'b011); clr = 1'b1; tick; clr = 1'b0;
    check("clr_rise_cnt", rise_cnt, 8'd0);
    check("clr_rise_cnt2", rise_cnt2, 2'd0);
    check("clr_rise_seen", seen, 8'h00);

    for (int k = 0; k < 3; k++) pulse();
    check("three_cnt", rise_cnt, 8'd3);
    check("three_S_q", S_q, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_cnt", rise_cnt, 8'd0);
    check("midrst_S_q", S_q, 1'b0);
    check("midrst_S", S, 1'b1);
    set_abc(3'b111);
    #1;
    check("midrst_S_follow", S, 1'b0);
    rst = 1'b0;
    set_abc(3'b011);
    tick;
    check("post_rst_cnt", rise_cnt, 8'd1);
    check("post_rst_S_q", S_q, 1'b1);
    check("post_rst_seen", seen, (SEEN_FULL != 8'h00) ? 8'h08 : 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/operations.md
OPERATIONS -- requirements
Module: operations

Interface
REQ-001 Parameter: CNT_W, default 8, width of the S rising-edge counter (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all registers update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: clr  input  1  synchronous clear of the counter and coverage state.
REQ-005 Port: A  input  1  operand A.
REQ-006 Port: B  input  1  operand B.
REQ-007 Port: C  input  1  operand C.
REQ-008 Port: S  output  1  combinational result.
REQ-009 Port: S_q  output  1  S registered by one clk.
REQ-010 Port: rise_cnt  output  CNT_W  count of S rising edges, saturating.
REQ-011 Port: seen  output  8  coverage bitmap of input combinations applied.
REQ-012 Port: all_seen  output  1  high when every bit of seen is 1.

Function
REQ-013 S SHALL equal (~A) & B & C, purely combinational, with no clock dependency.
- S=1 only for A=0, B=1, C=1; S=0 for the other seven combinations.
REQ-014 S SHALL be valid within the same simulation time step as any input change.
- No clock or reset is needed for S.
- rst SHALL NOT affect S.
REQ-015 S_q SHALL take the value of S on each rising clk edge when rst is low (latency 1 cycle).
REQ-016 A rising edge SHALL be detected at a clk edge where S=1 and S_q=0.
- On detection, rise_cnt SHALL increment by 1.
REQ-017 rise_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 Clear and rise in the same cycle: when clr=1, rise_cnt SHALL load 0 regardless of any simultaneous rise; clr has priority.
REQ-019 seen[{A,B,C}] SHALL be set to 1 on every rising clk edge; the index is {A,B,C}, with A as MSB.
- Bits SHALL stay set until clr or rst.
REQ-020 Clear and set in the same cycle: when clr=1, seen SHALL load 8'h00; clr has priority over setting the current index bit.
REQ-021 all_seen SHALL be combinational from the registered seen (all_seen = &seen).
REQ-022 clr SHALL NOT affect S_q.

Reset
REQ-023 While rst=1, the following SHALL be forced immediately, independent of clk: S_q=0, rise_cnt=0, seen=8'h00, all_seen=0.
REQ-024 After rst deasserts, the first rising clk edge SHALL perform normal updates.
- If S=1 at that edge, it SHALL count as a rising edge, because S_q was 0.
REQ-025 Asserting rst mid-operation SHALL discard all accumulated count and coverage state.

Configuration
REQ-026 Macro OPERATIONS_COV_EN controls the coverage logic.
- Defined: seen and all_seen SHALL behave per REQ-019..REQ-021.
- Undefined: the seen register SHALL NOT be built; seen SHALL be tied to 8'h00 and all_seen to 0.
- The port list SHALL be identical in both builds.
- S, S_q and rise_cnt SHALL be unaffected by the macro.

Verification
REQ-027 Reset, then sweep ABC through 000..111 at 10 ns steps.
- S SHALL be 1 only at 011.
- S SHALL be 0 at 000, 001, 010, 100, 101, 110 and 111.
REQ-028 Sweep all eight combinations, holding each for one clk.
- With OPERATIONS_COV_EN defined: seen=8'hFF and all_seen=1.
- Without it: seen=8'h00 and all_seen=0.
REQ-029 Toggle ABC between 011 and 111 every clk for 5 high pulses -> rise_cnt=5.
REQ-030 With CNT_W=2, produce 6 rising edges -> rise_cnt=3, with no wrap.
REQ-031 Assert clr on the same cycle as an S rising edge with rise_cnt=4 -> rise_cnt=0 and seen=8'h00.
REQ-032 Pulse rst between clk edges while rise_cnt=3 -> rise_cnt=0 and S_q=0 immediately, while S keeps following A, B and C.
